// File: rtl/psum_acc_ctrl_pkg.sv
// Shared definitions for the partial-sum accumulation controller:
// mac mode encodings and controller state encodings.
package psum_acc_ctrl_pkg;

   localparam logic [1:0] MODE_INT8     = 2'd0;
   localparam logic [1:0] MODE_INT4     = 2'd1;
   localparam logic [1:0] MODE_INT4_VSQ = 2'd2;

   typedef enum logic [1:0] {
      PSUM_ACC_IDLE = 2'd0,
      PSUM_ACC_ACC  = 2'd1,
      PSUM_ACC_OUT  = 2'd2
   } psum_acc_state_e;

endpackage

// File: rtl/psum_requant.sv
// Combinational requantizer: round-half-up arithmetic right shift of a signed
// accumulator, then saturation to a signed OUT_W result.
module psum_requant #(
   parameter int PSUM_W  = 24,
   parameter int OUT_W   = 8,
   parameter int SHIFT_W = 5
) (
   input  logic [PSUM_W-1:0]  x,
   input  logic [SHIFT_W-1:0] shift,
   output logic [OUT_W-1:0]   y
);

   logic signed [PSUM_W:0] xe;
   logic signed [PSUM_W:0] rnd;
   logic signed [PSUM_W:0] y_wide;
   logic                   fits;

   always_comb begin
      xe  = {x[PSUM_W-1], x};
      rnd = '0;
      if (shift != '0) rnd = (PSUM_W+1)'(1) << (shift - 1'b1);
      y_wide = (xe + rnd) >>> shift;
      // In range iff every bit above the OUT_W sign bit matches it.
      fits = (&y_wide[PSUM_W:OUT_W-1]) | ~(|y_wide[PSUM_W:OUT_W-1]);
      if (fits)                y = y_wide[OUT_W-1:0];
      else if (y_wide[PSUM_W]) y = {1'b1, {(OUT_W-1){1'b0}}};
      else                     y = {1'b0, {(OUT_W-1){1'b1}}};
   end

endmodule

// File: rtl/psum_acc_ctrl.sv
// Partial-sum accumulation controller: feeds psum back to the mac, counts
// K-tile beats per element, and presents the final and requantized result.
module psum_acc_ctrl
   import psum_acc_ctrl_pkg::*;
#(
   parameter int PSUM_W  = 24,
   parameter int CNT_W   = 8,
   parameter int OUT_W   = 8,
   parameter int SHIFT_W = 5
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic [CNT_W-1:0]   i_len,
   input  logic [1:0]         i_mode,
   input  logic [SHIFT_W-1:0] i_shift,
   output logic               o_busy,
   output logic [1:0]         o_mode,
   output logic [PSUM_W-1:0]  o_psum,
   output logic               o_res_ready,
   input  logic               i_res_valid,
   input  logic [PSUM_W-1:0]  i_result,
   output logic               o_out_valid,
   input  logic               i_out_ready,
   output logic [PSUM_W-1:0]  o_out_acc,
   output logic [OUT_W-1:0]   o_out_q
);

   psum_acc_state_e      state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [PSUM_W-1:0]    psum_q, psum_d;
   logic [1:0]           mode_q, mode_d;
   logic [SHIFT_W-1:0]   shift_q, shift_d;
   logic                 vld_q, vld_d;
   logic [PSUM_W-1:0]    acc_q, acc_d;
   logic [OUT_W-1:0]     q_q, q_d;
   logic [OUT_W-1:0]     req_q;
   logic                 start_ok;

   psum_requant #(.PSUM_W(PSUM_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)) u_requant (
      .x     (i_result),
      .shift (shift_q),
      .y     (req_q)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= PSUM_ACC_IDLE;
         cnt_q   <= '0;
         psum_q  <= '0;
         mode_q  <= '0;
         shift_q <= '0;
         vld_q   <= 1'b0;
         acc_q   <= '0;
         q_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         psum_q  <= psum_d;
         mode_q  <= mode_d;
         shift_q <= shift_d;
         vld_q   <= vld_d;
         acc_q   <= acc_d;
         q_q     <= q_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      psum_d   = psum_q;
      mode_d   = mode_q;
      shift_d  = shift_q;
      vld_d    = vld_q;
      acc_d    = acc_q;
      q_d      = q_q;
      start_ok = i_start && (i_len != '0);
      case (state_q)
         PSUM_ACC_IDLE: begin
            if (start_ok) begin
               mode_d  = i_mode;
               shift_d = i_shift;
               cnt_d   = i_len;
               psum_d  = '0;
               state_d = PSUM_ACC_ACC;
            end
         end
         PSUM_ACC_ACC: begin
            if (i_res_valid) begin
               cnt_d = cnt_q - 1'b1;
               // Clearing psum on the last beat keeps o_psum at zero outside ACC.
               if (cnt_q == CNT_W'(1)) begin
                  acc_d   = i_result;
                  q_d     = req_q;
                  vld_d   = 1'b1;
                  psum_d  = '0;
                  state_d = PSUM_ACC_OUT;
               end else begin
                  psum_d = i_result;
               end
            end
         end
         PSUM_ACC_OUT: begin
            if (i_out_ready) begin
               vld_d = 1'b0;
               if (start_ok) begin
                  mode_d  = i_mode;
                  shift_d = i_shift;
                  cnt_d   = i_len;
                  psum_d  = '0;
                  state_d = PSUM_ACC_ACC;
               end else begin
                  state_d = PSUM_ACC_IDLE;
               end
            end
         end
         default: state_d = PSUM_ACC_IDLE;
      endcase
   end

   assign o_busy      = (state_q != PSUM_ACC_IDLE);
   assign o_res_ready = (state_q == PSUM_ACC_ACC);
   assign o_mode      = mode_q;
   assign o_psum      = psum_q;
   assign o_out_valid = vld_q;
   assign o_out_acc   = acc_q;
   assign o_out_q     = q_q;

endmodule

// File: tb/tb_psum_acc_ctrl.sv
// Self-checking bench for psum_acc_ctrl: table-driven requant vectors, hand
// sequences for reset/stall/back-to-back corners, scoreboard on the output port.
module tb_psum_acc_ctrl;

   localparam int PSUM_W  = 24;
   localparam int CNT_W   = 8;
   localparam int OUT_W   = 8;
   localparam int SHIFT_W = 5;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               start = 1'b0;
   logic [CNT_W-1:0]   len = '0;
   logic [1:0]         mode = '0;
   logic [SHIFT_W-1:0] shift = '0;
   logic               busy;
   logic [1:0]         mode_o;
   logic [PSUM_W-1:0]  psum;
   logic               res_ready;
   logic               res_valid = 1'b0;
   logic [PSUM_W-1:0]  result = '0;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic [PSUM_W-1:0]  out_acc;
   logic [OUT_W-1:0]   out_q;

   typedef struct { int acc; int q; } exp_t;
   typedef struct { logic [SHIFT_W-1:0] shift; int acc; int q; } rq_vec_t;

   exp_t    sb[$];
   rq_vec_t vecs[11];
   int      checks = 0;
   int      failures = 0;

   psum_acc_ctrl #(.PSUM_W(PSUM_W), .CNT_W(CNT_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start),
      .i_len       (len),
      .i_mode      (mode),
      .i_shift     (shift),
      .o_busy      (busy),
      .o_mode      (mode_o),
      .o_psum      (psum),
      .o_res_ready (res_ready),
      .i_res_valid (res_valid),
      .i_result    (result),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_out_acc   (out_acc),
      .o_out_q     (out_q)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Scoreboard: every accepted output must match the oldest pending expectation.
   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out: got acc %0d with empty scoreboard", $signed(out_acc));
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("out_acc", int'($signed(out_acc)), e.acc);
            check("out_q", int'($signed(out_q)), e.q);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_elem(input int l, input int m, input int s);
      start = 1'b1;
      len   = CNT_W'(l);
      mode  = 2'(m);
      shift = SHIFT_W'(s);
      tick();
      start = 1'b0;
   endtask

   task automatic beat(input int r);
      res_valid = 1'b1;
      result    = PSUM_W'(r);
      tick();
      res_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
      if (!out_valid) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: got out_valid 0 expected 1");
      end else begin
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_mode"}, int'(mode_o), 0);
      check({tag, "_psum"}, int'(psum), 0);
      check({tag, "_res_ready"}, int'(res_ready), 0);
      check({tag, "_out_valid"}, int'(out_valid), 0);
      check({tag, "_out_acc"}, int'(out_acc), 0);
      check({tag, "_out_q"}, int'(out_q), 0);
   endtask

   initial begin
      vecs[0]  = '{SHIFT_W'(4), 24, 2};
      vecs[1]  = '{SHIFT_W'(4), -24, -1};
      vecs[2]  = '{SHIFT_W'(4), 100000, 127};
      vecs[3]  = '{SHIFT_W'(4), -100000, -128};
      vecs[4]  = '{SHIFT_W'(0), -128, -128};
      vecs[5]  = '{SHIFT_W'(0), 127, 127};
      vecs[6]  = '{SHIFT_W'(0), 128, 127};
      vecs[7]  = '{SHIFT_W'(1), 3, 2};
      vecs[8]  = '{SHIFT_W'(1), -3, -1};
      vecs[9]  = '{SHIFT_W'(2), -7, -2};
      vecs[10] = '{SHIFT_W'(8), 8388607, 127};

      // Power-on reset state
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      check_idle_outputs("por");

      // Reset aborts ACC after 2 of 4 beats; nothing is produced
      start_elem(4, 2, 3);
      beat(1);
      beat(2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_idle_outputs("abort");
      start_elem(1, 0, 0);
      sb.push_back('{5, 5});
      beat(5);
      drain();

      // Single element, psum feedback visible on o_psum
      start_elem(3, 1, 0);
      check("psum_b0", int'(psum), 0);
      check("res_ready_acc", int'(res_ready), 1);
      beat(10);
      check("psum_b1", int'(psum), 10);
      beat(30);
      check("psum_b2", int'(psum), 30);
      sb.push_back('{60, 60});
      beat(60);
      check("valid_after_last", int'(out_valid), 1);
      check("psum_out_zero", int'(psum), 0);
      drain();
      check("idle_after_hs", int'(busy), 0);

      // Stalls on both the result and output sides
      start_elem(2, 0, 0);
      beat(7);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("psum_hold", int'(psum), 7);
         check("valid_hold_low", int'(out_valid), 0);
      end
      sb.push_back('{16, 16});
      beat(16);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("out_stable_valid", int'(out_valid), 1);
         check("out_stable_acc", int'(out_acc), 16);
      end
      drain();
      check("stall_clear_valid", int'(out_valid), 0);
      check("stall_clear_busy", int'(busy), 0);

      // Requant / saturation table, mode rotates to exercise o_mode latching
      for (int i = 0; i < 11; i++) begin
         start_elem(1, i % 3, int'(vecs[i].shift));
         check("mode_latched", int'(mode_o), i % 3);
         sb.push_back('{vecs[i].acc, vecs[i].q});
         beat(vecs[i].acc);
         check("mode_in_out", int'(mode_o), i % 3);
         drain();
      end

      // Back-to-back start in the handshake cycle, start ignored during ACC
      start_elem(2, 0, 0);
      beat(1);
      sb.push_back('{3, 3});
      beat(3);
      out_ready = 1'b1;
      start = 1'b1; len = CNT_W'(2); mode = 2'd1; shift = '0;
      tick();
      out_ready = 1'b0;
      start = 1'b0;
      check("b2b_res_ready", int'(res_ready), 1);
      check("b2b_psum", int'(psum), 0);
      check("b2b_valid", int'(out_valid), 0);
      check("b2b_mode", int'(mode_o), 1);
      start = 1'b1; len = CNT_W'(5); mode = 2'd2;
      beat(4);
      start = 1'b0;
      check("acc_start_ignored_mode", int'(mode_o), 1);
      sb.push_back('{10, 10});
      beat(10);
      check("acc_start_ignored_cnt", int'(out_valid), 1);
      drain();

      // len=0 rejected
      start_elem(0, 1, 0);
      check("len0_busy", int'(busy), 0);
      check("len0_res_ready", int'(res_ready), 0);

      // Maximum length, all -1
      start_elem(255, 0, 0);
      for (int i = 0; i < 254; i++) beat(-1);
      check("len255_not_yet", int'(out_valid), 0);
      sb.push_back('{-1, -1});
      beat(-1);
      check("len255_valid", int'(out_valid), 1);
      drain();

      tick();
      check("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
